mmio_uart_tx: RTL and testbench

Memory-mapped UART transmitter that acts as a responder to the processor's data-memory store path, alongside the data memory.
- Processor stores to the transmit register push bytes into a small FIFO.
- A bit-timing state machine serialises each byte onto `tx` as a standard 8N1 frame.
- Loads from the status register return FIFO and transmitter state, so software can poll before writing.

---
 rtl/mmio_uart_tx.sv | 188 ++++++++++++++++++
 tb/tb_mmio_uart_tx.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: TXDATA pushes into a small FIFO, STATUS reports FIFO/FSM state.
// Optional even-parity bit is compiled in with `define UART_TX_PARITY_EN.
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0100,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  memwrite,
    input  logic [31:0] dataadr,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        hit,
    output logic        tx
);
    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [2:0]    bit_q, bit_d;
    logic          tx_q, tx_d;
    logic [7:0]    data_q, data_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic [7:0]    fifo_mem [FIFO_DEPTH];

    logic          wr_txdata, wr_status, full, empty, push, pop, timer_last;
    logic [4:0]    cnt5;
    logic [3:0]    cnt_sat;
    logic          unused_bits;

    assign unused_bits = ^{writedata[31:8], dataadr[1:0]};

    always_comb begin
        hit       = (dataadr[31:4] == BASE_ADDR[31:4]);
        wr_txdata = (|memwrite) && hit && (dataadr[3:2] == 2'd0);
        wr_status = (|memwrite) && hit && (dataadr[3:2] == 2'd1);
        full      = (count_q == CW'(FIFO_DEPTH));
        empty     = (count_q == '0);
        cnt5      = 5'(count_q);
        cnt_sat   = (cnt5 > 5'd15) ? 4'hF : cnt5[3:0];
        readdata  = 32'h0;
        if (hit && dataadr[3:2] == 2'd1)
            readdata = {24'h0, cnt_sat, ovf_q, empty, full, (state_q != S_IDLE)};
    end

    // Bit-timing FSM; tx_d is the line level for the cycle after the edge.
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        bit_d      = bit_q;
        tx_d       = tx_q;
        data_d     = data_q;
        pop        = 1'b0;
        timer_last = (timer_q == T_LAST);
        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (!empty) begin
                    pop     = 1'b1;
                    data_d  = fifo_mem[rd_ptr_q];
                    state_d = S_START;
                    timer_d = '0;
                    tx_d    = 1'b0;
                end
            end
            S_START: begin
                timer_d = timer_q + TW'(1);
                if (timer_last) begin
                    state_d = S_DATA;
                    timer_d = '0;
                    bit_d   = 3'd0;
                    tx_d    = data_q[0];
                end
            end
            S_DATA: begin
                timer_d = timer_q + TW'(1);
                if (timer_last) begin
                    timer_d = '0;
                    if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
                        tx_d    = ^data_q;
`else
                        state_d = S_STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        bit_d = bit_q + 3'd1;
                        tx_d  = data_q[bit_q + 3'd1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                timer_d = timer_q + TW'(1);
                if (timer_last) begin
                    state_d = S_STOP;
                    timer_d = '0;
                    tx_d    = 1'b1;
                end
            end
`endif
            S_STOP: begin
                timer_d = timer_q + TW'(1);
                if (timer_last) begin
                    timer_d = '0;
                    if (!empty) begin
                        pop     = 1'b1;
                        data_d  = fifo_mem[rd_ptr_q];
                        state_d = S_START;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                        tx_d    = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                timer_d = '0;
                tx_d    = 1'b1;
            end
        endcase
    end

    // A push into a full FIFO still lands when the FSM pops on the same edge.
    always_comb begin
        push     = wr_txdata && (!full || pop);
        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop)
            count_d = count_q + CW'(1);
        else if (pop && !push)
            count_d = count_q - CW'(1);
        ovf_d = ovf_q;
        if (wr_status && writedata[3])
            ovf_d = 1'b0;
        if (wr_txdata && full && !pop)
            ovf_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            timer_q  <= '0;
            bit_q    <= 3'd0;
            tx_q     <= 1'b1;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            bit_q    <= bit_d;
            tx_q     <= tx_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    always_ff @(posedge clk) begin
        data_q <= data_d;
        if (push)
            fifo_mem[wr_ptr_q] <= writedata[7:0];
    end

    assign tx = tx_q;
endmodule

// File: tb/tb_mmio_uart_tx.sv
// Directed bench for mmio_uart_tx with CLKS_PER_BIT=4, FIFO_DEPTH=4; honours UART_TX_PARITY_EN.
module tb_mmio_uart_tx;
    localparam logic [31:0] BASE = 32'h0000_0100;
    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int  NB  = 11;
    localparam bit  PAR = 1'b1;
`else
    localparam int  NB  = 10;
    localparam bit  PAR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  memwrite;
    logic [31:0] dataadr;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        hit;
    logic        tx;

    int vectors = 0;
    int miscompares = 0;

    mmio_uart_tx #(
        .BASE_ADDR(BASE),
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .memwrite(memwrite),
        .dataadr(dataadr),
        .writedata(writedata),
        .readdata(readdata),
        .hit(hit),
        .tx(tx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] addr, input logic [31:0] data);
        memwrite  = 2'b01;
        dataadr   = addr;
        writedata = data;
        tick();
        memwrite  = 2'b00;
        dataadr   = 32'h0;
        writedata = 32'h0;
    endtask

    task automatic rd_status(output logic [31:0] v);
        dataadr = BASE + 32'h4;
        #1;
        v = readdata;
        dataadr = 32'h0;
    endtask

    task automatic chk_status(input string tag, input logic [31:0] exp);
        logic [31:0] s;
        rd_status(s);
        chk(tag, s, exp);
    endtask

    // Walks one frame from cycle i0 of its start bit, checking the line and busy every cycle.
    task automatic frame(input logic [7:0] b, input int i0, input bit push_end, input logic [7:0] pb);
        logic [31:0] s;
        logic        e;
        int          k;
        for (int i = i0; i < NB * CPB; i++) begin
            k = i / CPB;
            if (k == 0)
                e = 1'b0;
            else if (k <= 8)
                e = b[k-1];
            else if (PAR && k == 9)
                e = ^b;
            else
                e = 1'b1;
            chk($sformatf("tx_%h_c%0d", b, i), {31'b0, tx}, {31'b0, e});
            rd_status(s);
            chk($sformatf("busy_%h_c%0d", b, i), {31'b0, s[0]}, 32'h1);
            if (push_end && i == NB * CPB - 1) begin
                memwrite  = 2'b11;
                dataadr   = BASE;
                writedata = {24'h0, pb};
            end
            tick();
            memwrite  = 2'b00;
            dataadr   = 32'h0;
            writedata = 32'h0;
        end
    endtask

    initial begin
        reset     = 1'b0;
        memwrite  = 2'b00;
        dataadr   = 32'h0;
        writedata = 32'h0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        chk("rst_tx", {31'b0, tx}, 32'h1);
        chk_status("rst_status", 32'h0000_0004);

        // Single byte
        store(BASE, 32'h0000_00A5);
        chk("single_tx_pre", {31'b0, tx}, 32'h1);
        chk_status("single_cnt1", 32'h0000_0010);
        tick();
        chk_status("single_started", 32'h0000_0005);
        frame(8'hA5, 0, 1'b0, 8'h00);
        chk("single_tx_idle", {31'b0, tx}, 32'h1);
        chk_status("single_done", 32'h0000_0004);

        // Back-to-back
        store(BASE, 32'h01);
        chk_status("b2b_cnt1", 32'h0000_0010);
        store(BASE, 32'h02);
        chk("b2b_fall", {31'b0, tx}, 32'h0);
        chk_status("b2b_cnt1b", 32'h0000_0011);
        store(BASE, 32'h03);
        chk_status("b2b_cnt2", 32'h0000_0021);
        frame(8'h01, 1, 1'b0, 8'h00);
        chk_status("b2b_after1", 32'h0000_0011);
        frame(8'h02, 0, 1'b0, 8'h00);
        chk_status("b2b_after2", 32'h0000_0005);
        frame(8'h03, 0, 1'b0, 8'h00);
        chk_status("b2b_done", 32'h0000_0004);

        // Overflow
        store(BASE, 32'h11);
        store(BASE, 32'h22);
        store(BASE, 32'h33);
        store(BASE, 32'h44);
        store(BASE, 32'h55);
        chk_status("ovf_full", 32'h0000_0043);
        store(BASE, 32'h66);
        chk_status("ovf_set", 32'h0000_004B);
        store(BASE + 32'h4, 32'hF7);
        chk_status("ovf_keep", 32'h0000_004B);
        store(BASE + 32'h4, 32'h8);
        chk_status("ovf_clr", 32'h0000_0043);
        frame(8'h11, 6, 1'b0, 8'h00);
        frame(8'h22, 0, 1'b0, 8'h00);
        frame(8'h33, 0, 1'b0, 8'h00);
        frame(8'h44, 0, 1'b0, 8'h00);
        frame(8'h55, 0, 1'b0, 8'h00);
        chk_status("ovf_done", 32'h0000_0004);
        tick();
        tick();
        chk("ovf_no_sixth", {31'b0, tx}, 32'h1);

        // Push/pop collision at stop-end
        store(BASE, 32'hA1);
        store(BASE, 32'hB2);
        store(BASE, 32'hC3);
        store(BASE, 32'hD4);
        store(BASE, 32'hE5);
        chk_status("col_full", 32'h0000_0043);
        frame(8'hA1, 3, 1'b1, 8'hF6);
        chk_status("col_after", 32'h0000_0043);
        frame(8'hB2, 0, 1'b0, 8'h00);
        frame(8'hC3, 0, 1'b0, 8'h00);
        frame(8'hD4, 0, 1'b0, 8'h00);
        frame(8'hE5, 0, 1'b0, 8'h00);
        frame(8'hF6, 0, 1'b0, 8'h00);
        chk_status("col_done", 32'h0000_0004);

        // Decode
        store(BASE + 32'h8, 32'h77);
        store(BASE + 32'h10, 32'h88);
        chk_status("dec_nochange", 32'h0000_0004);
        dataadr = BASE + 32'h10;
        #1;
        chk("dec_hit16", {31'b0, hit}, 32'h0);
        chk("dec_rd16", readdata, 32'h0);
        dataadr = BASE;
        #1;
        chk("dec_hit0", {31'b0, hit}, 32'h1);
        chk("dec_rd0", readdata, 32'h0);
        dataadr = BASE + 32'h8;
        #1;
        chk("dec_rd8", readdata, 32'h0);
        dataadr = 32'h0;
        tick();
        tick();
        chk("dec_tx_idle", {31'b0, tx}, 32'h1);

        // Reset mid-frame
        store(BASE, 32'h00);
        for (int i = 0; i < 6; i++) tick();
        chk("mid_tx_low", {31'b0, tx}, 32'h0);
        #2;
        reset = 1'b0;
        #1;
        chk("mid_tx_async", {31'b0, tx}, 32'h1);
        tick();
        tick();
        reset = 1'b1;
        tick();
        chk_status("mid_status", 32'h0000_0004);
        for (int i = 0; i < 8; i++) tick();
        chk("mid_abandoned", {31'b0, tx}, 32'h1);
        chk_status("mid_status2", 32'h0000_0004);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
